// File: rtl/decode_out_producer.sv
// LC-3 decode stage: registers IR/next-PC and drives E/W/Mem control words to execute.
// Optional sticky illegal-opcode flag and saturating counter via `DECODE_OUT_ILLEGAL_DETECT_EN.
module decode_out_producer
`ifdef DECODE_OUT_ILLEGAL_DETECT_EN
   #(parameter int ILLEGAL_CNT_WIDTH = 8)
`endif
(
   input  logic        clock,
   input  logic        reset,
   input  logic        enable_decode,
   input  logic [15:0] dout,
   input  logic [15:0] npc_in,
   output logic [15:0] IR,
   output logic [15:0] npc_out,
   output logic [5:0]  E_control,
   output logic [1:0]  W_control,
   output logic        Mem_control
`ifdef DECODE_OUT_ILLEGAL_DETECT_EN
   ,
   output logic        illegal_op,
   output logic [ILLEGAL_CNT_WIDTH-1:0] illegal_cnt
`endif
);

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_ST  = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_STR = 4'b0111;
   localparam logic [3:0] OP_NOT = 4'b1001;
   localparam logic [3:0] OP_LDI = 4'b1010;
   localparam logic [3:0] OP_STI = 4'b1011;
   localparam logic [3:0] OP_JMP = 4'b1100;
   localparam logic [3:0] OP_LEA = 4'b1110;

   logic [15:0] ir_d, ir_q;
   logic [15:0] npc_d, npc_q;
   logic [5:0]  e_ctrl_d, e_ctrl_q;
   logic [1:0]  w_ctrl_d, w_ctrl_q;
   logic        mem_ctrl_d, mem_ctrl_q;

   logic [1:0]  dec_alu;
   logic [1:0]  dec_pcsel1;
   logic        dec_pcsel2;
   logic        dec_op2sel;
   logic [1:0]  dec_w;
   logic        dec_mem;
   logic        dec_illegal;

   // Field decode of the incoming word; unlisted fields stay zero.
   always_comb begin
      dec_alu     = 2'b00;
      dec_pcsel1  = 2'b00;
      dec_pcsel2  = 1'b0;
      dec_op2sel  = 1'b0;
      dec_w       = 2'b00;
      dec_mem     = 1'b0;
      dec_illegal = 1'b0;
      case (dout[15:12])
         OP_ADD: begin dec_alu = 2'b00; dec_op2sel = ~dout[5]; end
         OP_AND: begin dec_alu = 2'b01; dec_op2sel = ~dout[5]; end
         OP_NOT: dec_alu = 2'b10;
         OP_BR:  begin dec_pcsel1 = 2'b01; dec_pcsel2 = 1'b1; end
         OP_JMP: dec_pcsel1 = 2'b11;
         OP_LD:  begin dec_pcsel1 = 2'b01; dec_pcsel2 = 1'b1; dec_w = 2'b01; end
         OP_LDR: begin dec_pcsel1 = 2'b10; dec_w = 2'b01; end
         OP_LDI: begin dec_pcsel1 = 2'b01; dec_pcsel2 = 1'b1; dec_w = 2'b01; dec_mem = 1'b1; end
         OP_LEA: begin dec_pcsel1 = 2'b01; dec_pcsel2 = 1'b1; dec_w = 2'b10; end
         OP_ST:  begin dec_pcsel1 = 2'b01; dec_pcsel2 = 1'b1; end
         OP_STR: dec_pcsel1 = 2'b10;
         OP_STI: begin dec_pcsel1 = 2'b01; dec_pcsel2 = 1'b1; dec_mem = 1'b1; end
         default: dec_illegal = 1'b1;
      endcase
   end

   always_comb begin
      ir_d       = ir_q;
      npc_d      = npc_q;
      e_ctrl_d   = e_ctrl_q;
      w_ctrl_d   = w_ctrl_q;
      mem_ctrl_d = mem_ctrl_q;
      if (enable_decode) begin
         ir_d       = dout;
         npc_d      = npc_in;
         e_ctrl_d   = {dec_alu, dec_pcsel1, dec_pcsel2, dec_op2sel};
         w_ctrl_d   = dec_w;
         mem_ctrl_d = dec_mem;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ir_q       <= '0;
         npc_q      <= '0;
         e_ctrl_q   <= '0;
         w_ctrl_q   <= '0;
         mem_ctrl_q <= 1'b0;
      end else begin
         ir_q       <= ir_d;
         npc_q      <= npc_d;
         e_ctrl_q   <= e_ctrl_d;
         w_ctrl_q   <= w_ctrl_d;
         mem_ctrl_q <= mem_ctrl_d;
      end
   end

   assign IR          = ir_q;
   assign npc_out     = npc_q;
   assign E_control   = e_ctrl_q;
   assign W_control   = w_ctrl_q;
   assign Mem_control = mem_ctrl_q;

`ifdef DECODE_OUT_ILLEGAL_DETECT_EN
   logic                         illegal_op_d, illegal_op_q;
   logic [ILLEGAL_CNT_WIDTH-1:0] illegal_cnt_d, illegal_cnt_q;

   // Counter sticks at all-ones instead of wrapping.
   always_comb begin
      illegal_op_d  = illegal_op_q;
      illegal_cnt_d = illegal_cnt_q;
      if (enable_decode && dec_illegal) begin
         illegal_op_d = 1'b1;
         if (illegal_cnt_q != {ILLEGAL_CNT_WIDTH{1'b1}})
            illegal_cnt_d = illegal_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         illegal_op_q  <= 1'b0;
         illegal_cnt_q <= '0;
      end else begin
         illegal_op_q  <= illegal_op_d;
         illegal_cnt_q <= illegal_cnt_d;
      end
   end

   assign illegal_op  = illegal_op_q;
   assign illegal_cnt = illegal_cnt_q;
`else
   logic unused_illegal;
   assign unused_illegal = dec_illegal;
`endif

endmodule

// File: tb/tb_decode_out_producer.sv
// Bench for decode_out_producer: directed vector table, hand sequences and a randomized
// run against a rule-based reference model (illegal-op checks when the macro is defined).
module tb_decode_out_producer;

   localparam int CW = 2;

   logic        clock;
   logic        reset;
   logic        enable_decode;
   logic [15:0] dout;
   logic [15:0] npc_in;
   logic [15:0] IR;
   logic [15:0] npc_out;
   logic [5:0]  E_control;
   logic [1:0]  W_control;
   logic        Mem_control;
`ifdef DECODE_OUT_ILLEGAL_DETECT_EN
   logic          illegal_op;
   logic [CW-1:0] illegal_cnt;
`endif

   int checks = 0;
   int errors = 0;

`ifdef DECODE_OUT_ILLEGAL_DETECT_EN
   decode_out_producer #(.ILLEGAL_CNT_WIDTH(CW)) dut (
      .clock(clock), .reset(reset), .enable_decode(enable_decode),
      .dout(dout), .npc_in(npc_in), .IR(IR), .npc_out(npc_out),
      .E_control(E_control), .W_control(W_control), .Mem_control(Mem_control),
      .illegal_op(illegal_op), .illegal_cnt(illegal_cnt));
`else
   decode_out_producer dut (
      .clock(clock), .reset(reset), .enable_decode(enable_decode),
      .dout(dout), .npc_in(npc_in), .IR(IR), .npc_out(npc_out),
      .E_control(E_control), .W_control(W_control), .Mem_control(Mem_control));
`endif

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model state
   int m_ir, m_npc, m_e, m_w, m_mem, m_ill, m_cnt;

   task automatic ref_decode(input int word, output int e, output int w, output int mem,
                             output int illegal);
      int alu, ps1, ps2, op2;
      alu = 0; ps1 = 0; ps2 = 0; op2 = 0; w = 0; mem = 0; illegal = 0;
      case ((word >> 12) & 15)
         1:  begin alu = 0; op2 = ((word >> 5) & 1) ? 0 : 1; end
         5:  begin alu = 1; op2 = ((word >> 5) & 1) ? 0 : 1; end
         9:  alu = 2;
         0:  begin ps1 = 1; ps2 = 1; end
         12: ps1 = 3;
         2:  begin ps1 = 1; ps2 = 1; w = 1; end
         6:  begin ps1 = 2; w = 1; end
         10: begin ps1 = 1; ps2 = 1; w = 1; mem = 1; end
         14: begin ps1 = 1; ps2 = 1; w = 2; end
         3:  begin ps1 = 1; ps2 = 1; end
         7:  ps1 = 2;
         11: begin ps1 = 1; ps2 = 1; mem = 1; end
         default: illegal = 1;
      endcase
      e = alu * 16 + ps1 * 4 + ps2 * 2 + op2;
   endtask

   task automatic model_apply(input bit rst, input bit en, input int word, input int npc);
      int e, w, mem, ill;
      if (rst) begin
         m_ir = 0; m_npc = 0; m_e = 0; m_w = 0; m_mem = 0; m_ill = 0; m_cnt = 0;
      end else if (en) begin
         ref_decode(word, e, w, mem, ill);
         m_ir = word; m_npc = npc; m_e = e; m_w = w; m_mem = mem;
         if (ill != 0) begin
            m_ill = 1;
            if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle's inputs, let the edge happen, sample 1 time unit later.
   task automatic step(input bit rst, input bit en, input logic [15:0] word,
                       input logic [15:0] npc);
      reset = rst; enable_decode = en; dout = word; npc_in = npc;
      @(posedge clock);
      #1;
      model_apply(rst, en, int'(word), int'(npc));
   endtask

   task automatic check_model(input string tag);
      check({tag, ".IR"},  {16'h0, IR},          m_ir);
      check({tag, ".npc"}, {16'h0, npc_out},     m_npc);
      check({tag, ".E"},   {26'h0, E_control},   m_e);
      check({tag, ".W"},   {30'h0, W_control},   m_w);
      check({tag, ".Mem"}, {31'h0, Mem_control}, m_mem);
`ifdef DECODE_OUT_ILLEGAL_DETECT_EN
      check({tag, ".ill"}, {31'h0, illegal_op},  m_ill);
      check({tag, ".cnt"}, {30'h0, illegal_cnt}, m_cnt);
`endif
   endtask

   typedef struct {
      bit          rst;
      bit          en;
      logic [15:0] word;
      logic [15:0] npc;
      logic [15:0] exp_ir;
      logic [15:0] exp_npc;
      logic [5:0]  exp_e;
      logic [1:0]  exp_w;
      logic        exp_mem;
   } vec_t;

   vec_t vecs[16];

   initial begin
      reset = 1'b1; enable_decode = 1'b1; dout = 16'h12A5; npc_in = 16'h0;

      // rst en dout npc | IR npc E W Mem
      vecs[0]  = '{1, 1, 16'h12A5, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 2'b00, 1'b0};
      vecs[1]  = '{1, 1, 16'h12A5, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 2'b00, 1'b0};
      vecs[2]  = '{0, 1, 16'h12A5, 16'h3000, 16'h12A5, 16'h3000, 6'b000000, 2'b00, 1'b0};
      vecs[3]  = '{0, 1, 16'h1283, 16'h3001, 16'h1283, 16'h3001, 6'b000001, 2'b00, 1'b0};
      vecs[4]  = '{0, 1, 16'hA003, 16'h3001, 16'hA003, 16'h3001, 6'b000110, 2'b01, 1'b1};
      vecs[5]  = '{0, 1, 16'h6284, 16'h3002, 16'h6284, 16'h3002, 6'b001000, 2'b01, 1'b0};
      vecs[6]  = '{0, 1, 16'h92BF, 16'h3003, 16'h92BF, 16'h3003, 6'b100000, 2'b00, 1'b0};
      vecs[7]  = '{0, 0, 16'hE00A, 16'h4000, 16'h92BF, 16'h3003, 6'b100000, 2'b00, 1'b0};
      vecs[8]  = '{0, 0, 16'hE00A, 16'h4000, 16'h92BF, 16'h3003, 6'b100000, 2'b00, 1'b0};
      vecs[9]  = '{0, 0, 16'hE00A, 16'h4000, 16'h92BF, 16'h3003, 6'b100000, 2'b00, 1'b0};
      vecs[10] = '{0, 0, 16'hE00A, 16'h4000, 16'h92BF, 16'h3003, 6'b100000, 2'b00, 1'b0};
      vecs[11] = '{0, 0, 16'hE00A, 16'h4000, 16'h92BF, 16'h3003, 6'b100000, 2'b00, 1'b0};
      vecs[12] = '{0, 1, 16'hE00A, 16'h4000, 16'hE00A, 16'h4000, 6'b000110, 2'b10, 1'b0};
      vecs[13] = '{0, 1, 16'h2005, 16'h4001, 16'h2005, 16'h4001, 6'b000110, 2'b01, 1'b0};
      vecs[14] = '{1, 1, 16'h2005, 16'h4002, 16'h0000, 16'h0000, 6'b000000, 2'b00, 1'b0};
      vecs[15] = '{0, 1, 16'h2005, 16'h4003, 16'h2005, 16'h4003, 6'b000110, 2'b01, 1'b0};

      for (int i = 0; i < 16; i++) begin
         step(vecs[i].rst, vecs[i].en, vecs[i].word, vecs[i].npc);
         check($sformatf("vec%0d.IR", i),  {16'h0, IR},          {16'h0, vecs[i].exp_ir});
         check($sformatf("vec%0d.npc", i), {16'h0, npc_out},     {16'h0, vecs[i].exp_npc});
         check($sformatf("vec%0d.E", i),   {26'h0, E_control},   {26'h0, vecs[i].exp_e});
         check($sformatf("vec%0d.W", i),   {30'h0, W_control},   {30'h0, vecs[i].exp_w});
         check($sformatf("vec%0d.Mem", i), {31'h0, Mem_control}, {31'h0, vecs[i].exp_mem});
`ifdef DECODE_OUT_ILLEGAL_DETECT_EN
         check($sformatf("vec%0d.ill", i), {31'h0, illegal_op},  32'h0);
`endif
      end

      // Illegal opcode captures zero the controls but still take IR/npc.
      step(0, 1, 16'hD123, 16'h5000);
      check("illegal.IR", {16'h0, IR},        32'hD123);
      check("illegal.E",  {26'h0, E_control}, 32'h0);
      check("illegal.W",  {30'h0, W_control}, 32'h0);

`ifdef DECODE_OUT_ILLEGAL_DETECT_EN
      step(1, 0, 16'h0000, 16'h0000);
      begin
         int exp_cnt[5] = '{1, 2, 3, 3, 3};
         for (int i = 0; i < 5; i++) begin
            step(0, 1, 16'hD000, 16'h6000);
            check($sformatf("sat%0d.cnt", i), {30'h0, illegal_cnt}, exp_cnt[i]);
            check($sformatf("sat%0d.ill", i), {31'h0, illegal_op},  32'h1);
            check($sformatf("sat%0d.E", i),   {26'h0, E_control},   32'h0);
         end
      end
      step(0, 1, 16'h1283, 16'h6001);
      check("sticky.ill", {31'h0, illegal_op},  32'h1);
      check("sticky.cnt", {30'h0, illegal_cnt}, 32'h3);
      check("sticky.E",   {26'h0, E_control},   32'h1);
      step(1, 0, 16'h0000, 16'h0000);
      step(0, 0, 16'h8000, 16'h0000);
      check("disabled.cnt", {30'h0, illegal_cnt}, 32'h0);
      check("disabled.ill", {31'h0, illegal_op},  32'h0);
      step(0, 1, 16'hF000, 16'h0000);
      check("one.cnt", {30'h0, illegal_cnt}, 32'h1);
`endif

      // Randomized run against the reference model.
      for (int i = 0; i < 400; i++) begin
         bit          r, e;
         logic [15:0] w, n;
         r = ($urandom_range(0, 31) == 0);
         e = ($urandom_range(0, 3) != 0);
         w = 16'($urandom_range(0, 65535));
         n = 16'($urandom_range(0, 65535));
         step(r, e, w, n);
         check_model($sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/decode_out_producer.md
Name: decode_out_producer

Overview:
- RTL LC-3 decode stage: the producer end of the decode_out interface.
- Registers the fetched instruction word and next-PC, decodes the opcode, and drives IR, npc_out, E_control, W_control and Mem_control to the execute stage.
- The decode_out agent, in passive/INITIATOR-side monitoring, observes these outputs. This block is the DUT-side source those agents check against.

Parameters:
- ILLEGAL_CNT_WIDTH, 8, width of the saturating illegal-opcode counter. Used only when the optional feature is compiled in.

Ports:
- clock          input   1   rising-edge clock
- reset          input   1   synchronous, active-high reset
- enable_decode  input   1   1 = capture and decode this cycle; 0 = hold all outputs
- dout           input   16  instruction word from fetch/memory
- npc_in         input   16  next-PC from fetch
- IR             output  16  registered instruction
- npc_out        output  16  registered next-PC
- E_control      output  6   {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
- W_control      output  2   writeback mux select: 00 = ALU, 01 = memory, 10 = PC (LEA)
- Mem_control    output  1   1 = indirect memory access (LDI/STI)
- illegal_op     output  1   sticky illegal-opcode flag (optional feature only)
- illegal_cnt    output  ILLEGAL_CNT_WIDTH  saturating illegal-opcode count (optional feature only)

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high on `reset`, sampled on the rising edge of `clock`. Reset has priority over enable_decode.
- Reset values: IR = 0, npc_out = 0, E_control = 0, W_control = 0, Mem_control = 0, illegal_op = 0, illegal_cnt = 0.
- Latency: 1 cycle. With enable_decode = 1 at edge N, all outputs reflect dout/npc_in sampled at edge N, visible after edge N.
- Hold: with enable_decode = 0, every output register holds its value, including across many cycles.
- Decode (op = dout[15:12]). All fields not listed are 0.
  - ADD 0001: alu 00, op2select = ~dout[5], W 00
  - AND 0101: alu 01, op2select = ~dout[5], W 00
  - NOT 1001: alu 10, op2select 0, W 00
  - BR 0000: pcselect1 01, pcselect2 1, W 00
  - JMP 1100: pcselect1 11, pcselect2 0, W 00
  - LD 0010: pcselect1 01, pcselect2 1, W 01, Mem 0
  - LDR 0110: pcselect1 10, pcselect2 0, W 01, Mem 0
  - LDI 1010: pcselect1 01, pcselect2 1, W 01, Mem 1
  - LEA 1110: pcselect1 01, pcselect2 1, W 10
  - ST 0011: pcselect1 01, pcselect2 1, W 00, Mem 0
  - STR 0111: pcselect1 10, pcselect2 0, W 00, Mem 0
  - STI 1011: pcselect1 01, pcselect2 1, W 00, Mem 1
  - Illegal (0100, 1000, 1101, 1111): E_control = 0, W_control = 0, Mem_control = 0. IR and npc_out are still captured.
- Decode is purely a function of the captured dout. No cross-instruction state except the optional counters.
- Reset asserted in the same cycle as enable_decode = 1: reset wins and all outputs go to 0.
- Outputs never go X or Z after the first reset edge.

Optional Feature:
- Macro: DECODE_OUT_ILLEGAL_DETECT_EN
- Defined:
  - illegal_op and illegal_cnt ports exist.
  - On any enabled capture of an illegal opcode, illegal_op is set to 1 (sticky until reset) and illegal_cnt increments by 1.
  - illegal_cnt saturates at 2^ILLEGAL_CNT_WIDTH - 1 and does not wrap.
  - Captures with enable_decode = 0 do not count.
- Undefined: both ports are absent. Illegal opcodes decode to all-zero controls as above, with no other effect.

Test Plan:
- Reset: assert reset for 2 cycles while dout = 0x12A5 and enable_decode = 1 -> all outputs 0; the cycle after reset deasserts, IR = 0x12A5.
- ADD imm then ADD reg: dout = 0x12A5 (ADD R1,R2,#5) -> E_control = 6'b000000, W = 00. Next cycle dout = 0x1283 (ADD R1,R2,R3) -> E_control = 6'b000001.
- Memory ops: dout = 0xA003 (LDI), npc_in = 0x3001 -> E_control = 6'b000110, W = 01, Mem = 1, npc_out = 0x3001. Then dout = 0x6284 (LDR) -> E_control = 6'b001000, W = 01, Mem = 0.
- Hold: decode dout = 0x92BF (NOT), expect E_control = 6'b100000. Then enable_decode = 0 for 5 cycles with dout = 0xE00A -> outputs unchanged. Re-enable -> W = 10, E_control = 6'b000110.
- Reset mid-stream: reset pulsed for 1 cycle between two enabled LD (0x2005) captures -> outputs 0 for exactly that cycle, then LD decode resumes.
- With DECODE_OUT_ILLEGAL_DETECT_EN and ILLEGAL_CNT_WIDTH = 2: feed dout = 0xD000 for 5 enabled cycles -> controls 0, illegal_op = 1, illegal_cnt sequence 1, 2, 3, 3, 3. A subsequent legal op leaves illegal_op = 1.
